// File: rtl/fsk_measurement_controller_pkg.sv
// Shared definitions for the FSK measurement controller slice.
//   state_t        : controller FSM states (also exported on the debug port)
//   symbol_t       : decided symbol codes carried on result_symbol
//   SETTLE_CYCLES  : cycles the analyzer is held disabled before capture
//   COUNT_W        : width of window counter and analyzer accumulators
//   OVERRUN_W      : width of the saturating overrun counter
package fsk_measurement_controller_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SYM_NONE   = 2'd0,
    SYM_F0     = 2'd1,
    SYM_F1     = 2'd2,
    SYM_REJECT = 2'd3
  } symbol_t;

  localparam int SETTLE_CYCLES = 2;
  localparam int COUNT_W       = 32;
  localparam int OVERRUN_W     = 16;

endpackage

// File: rtl/fsk_measurement_controller_if.sv
// Result channel of the FSK measurement controller.
//
// Handshake: the master raises result_valid with a complete result
// (symbol + three counts) and holds every field stable until it sees
// result_valid & result_ready high on the same rising clock edge; that edge
// is the transfer. The slave may drive result_ready at any time, and the
// master never waits on result_ready before raising result_valid.
//
//   master : controller side (drives valid and payload, reads ready)
//   slave  : consumer side   (reads valid and payload, drives ready)
interface fsk_measurement_controller_if;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_symbol;
  logic [31:0] result_f0;
  logic [31:0] result_f1;
  logic [31:0] result_unknown;

  modport master (
    output result_valid,
    output result_symbol,
    output result_f0,
    output result_f1,
    output result_unknown,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_symbol,
    input  result_f0,
    input  result_f1,
    input  result_unknown,
    output result_ready
  );
endinterface

// File: rtl/fsk_symbol_decider.sv
// Combinational symbol decision from the three analyzer accumulators.
//   f0_count, f1_count, unknown_count : 32-bit counts from the analyzer
//   symbol                            : 2-bit symbol code (symbol_t)
// A symbol wins only when its count is strictly larger than both others;
// any tie gives SYM_NONE.
// Optional feature macro: FSK_CTRL_UNKNOWN_REJECT_EN. When defined, a window
// whose unknown share exceeds UNKNOWN_LIMIT_PERCENT of all counts is marked
// SYM_REJECT, overriding the f0/f1 decision. When undefined no multiplier
// exists and SYM_REJECT is never produced.
module fsk_symbol_decider
  import fsk_measurement_controller_pkg::*;
#(
  parameter int UNKNOWN_LIMIT_PERCENT = 25
) (
  input  logic [31:0] f0_count,
  input  logic [31:0] f1_count,
  input  logic [31:0] unknown_count,
  output logic [1:0]  symbol
);

  logic [1:0] tone_symbol;

  always_comb begin
    tone_symbol = SYM_NONE;
    if ((f0_count > f1_count) && (f0_count > unknown_count)) begin
      tone_symbol = SYM_F0;
    end else if ((f1_count > f0_count) && (f1_count > unknown_count)) begin
      tone_symbol = SYM_F1;
    end
  end

`ifdef FSK_CTRL_UNKNOWN_REJECT_EN
  // Sum of three 32-bit values needs 34 bits; scaling by at most 100 keeps
  // both sides of the compare inside 41 bits, so nothing can wrap.
  logic [33:0] total_count;
  logic [40:0] unknown_scaled;
  logic [40:0] limit_scaled;
  logic        reject;

  always_comb begin
    total_count    = {2'b00, f0_count} + {2'b00, f1_count} + {2'b00, unknown_count};
    unknown_scaled = {9'd0, unknown_count} * 41'd100;
    limit_scaled   = {7'd0, total_count} * 41'(UNKNOWN_LIMIT_PERCENT);
    reject         = unknown_scaled > limit_scaled;
  end

  assign symbol = reject ? SYM_REJECT : tone_symbol;
`else
  assign symbol = tone_symbol;
`endif

endmodule

// File: rtl/fsk_measurement_controller.sv
// FSK measurement controller: sequences an external tone analyzer through
// repeated measurement windows and publishes one decided symbol per window.
//
// Window cycle: CLEAR (1 cycle, analyzer_clear low) -> MEASURE (analyzer
// enabled for the latched window length) -> SETTLE (SETTLE_CYCLES, analyzer
// disabled so it can flush into its unknown bin) -> CAPTURE (1 cycle, counts
// registered and symbol decided) -> CLEAR again while running, else IDLE.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   start, stop         : pulses; start begins continuous measurement in IDLE,
//                         stop ends the run after the current window
//   window_ticks        : window length in clocks, 0 selects DEFAULT_WINDOW_TICKS
//   analyzer_enable     : analyzer counts while high
//   analyzer_clear      : active-low analyzer clear
//   f0_value, f1_value, unknown : analyzer accumulators
//   result_if (master)  : result channel (valid/ready, symbol, three counts)
//   busy                : high in every state except IDLE
//   overrun_count       : saturating count of results dropped because the
//                         previous one was still waiting
//   state_dbg           : current FSM state
// Optional feature macro: FSK_CTRL_UNKNOWN_REJECT_EN (see fsk_symbol_decider).
module fsk_measurement_controller
  import fsk_measurement_controller_pkg::*;
#(
  parameter int unsigned DEFAULT_WINDOW_TICKS  = 500000,
  parameter int          UNKNOWN_LIMIT_PERCENT = 25
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [COUNT_W-1:0]           window_ticks,
  output logic                         analyzer_enable,
  output logic                         analyzer_clear,
  input  logic [COUNT_W-1:0]           f0_value,
  input  logic [COUNT_W-1:0]           f1_value,
  input  logic [COUNT_W-1:0]           unknown,
  fsk_measurement_controller_if.master result_if,
  output logic                         busy,
  output logic [OVERRUN_W-1:0]         overrun_count,
  output state_t                       state_dbg
);

  localparam logic [COUNT_W-1:0]   DEFAULT_WINDOW = COUNT_W'(DEFAULT_WINDOW_TICKS);
  localparam logic [1:0]           SETTLE_LAST    = 2'(SETTLE_CYCLES - 1);
  localparam logic [OVERRUN_W-1:0] OVERRUN_MAX    = '1;

  state_t               state_q;
  state_t               state_d;
  logic [COUNT_W-1:0]   window_q;
  logic [COUNT_W-1:0]   count_q;
  logic [1:0]           settle_q;
  logic                 stop_pending_q;

  logic                 valid_q;
  logic [1:0]           symbol_q;
  logic [COUNT_W-1:0]   f0_q;
  logic [COUNT_W-1:0]   f1_q;
  logic [COUNT_W-1:0]   unknown_q;
  logic [OVERRUN_W-1:0] overrun_q;

  logic [1:0]           decided_symbol;
  logic                 capture;
  logic                 accept;
  logic                 load_result;

  fsk_symbol_decider #(
    .UNKNOWN_LIMIT_PERCENT (UNKNOWN_LIMIT_PERCENT)
  ) u_decider (
    .f0_count      (f0_value),
    .f1_count      (f1_value),
    .unknown_count (unknown),
    .symbol        (decided_symbol)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and analyzer controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    analyzer_enable = 1'b0;
    analyzer_clear  = 1'b1;
    busy            = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        analyzer_clear = 1'b0;
        state_d        = MEASURE;
      end
      MEASURE: begin
        analyzer_enable = 1'b1;
        // count_q holds the cycles left including this one
        if (count_q <= COUNT_W'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // a stop arriving in the capture cycle itself also ends the run
        state_d = (stop_pending_q || stop) ? IDLE : CLEAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Window length, window counter, settle counter, stop request
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window_q       <= '0;
      count_q        <= '0;
      settle_q       <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        window_q <= (window_ticks == '0) ? DEFAULT_WINDOW : window_ticks;
      end

      if (state_q == CLEAR) begin
        count_q <= window_q;
      end else if (state_q == MEASURE) begin
        count_q <= count_q - COUNT_W'(1);
      end

      settle_q <= (state_q == SETTLE) ? settle_q + 2'd1 : 2'd0;

      // In IDLE the request is cleared, except that a stop arriving together
      // with the accepted start limits the run to a single window.
      if (state_q == IDLE) begin
        stop_pending_q <= start && stop;
      end else if (stop) begin
        stop_pending_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result register and overrun counter
  // ---------------------------------------------------------------------
  assign capture     = (state_q == CAPTURE);
  assign accept      = valid_q && result_if.result_ready;
  // A capture may replace the held result only if the slot is empty or is
  // being transferred on this very edge; otherwise it is dropped.
  assign load_result = capture && (!valid_q || result_if.result_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      symbol_q  <= SYM_NONE;
      f0_q      <= '0;
      f1_q      <= '0;
      unknown_q <= '0;
      overrun_q <= '0;
    end else begin
      if (load_result) begin
        valid_q   <= 1'b1;
        symbol_q  <= decided_symbol;
        f0_q      <= f0_value;
        f1_q      <= f1_value;
        unknown_q <= unknown;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (capture && !load_result && overrun_q != OVERRUN_MAX) begin
        overrun_q <= overrun_q + OVERRUN_W'(1);
      end
    end
  end

  assign result_if.result_valid   = valid_q;
  assign result_if.result_symbol  = symbol_q;
  assign result_if.result_f0      = f0_q;
  assign result_if.result_f1      = f1_q;
  assign result_if.result_unknown = unknown_q;
  assign overrun_count            = overrun_q;
  assign state_dbg                = state_q;

endmodule

// File: tb/tb_fsk_measurement_controller.sv
// Bench for fsk_measurement_controller: a simple analyzer model accumulates
// per enabled cycle into a tone bin (optionally with random noise), or
// drives direct random counts; a monitor scores every transfer against the
// counts present at capture and a reference symbol rule.
module tb_fsk_measurement_controller;
  import fsk_measurement_controller_pkg::*;

  localparam int DEF_WINDOW = 20000;
  localparam int LIMIT_PCT  = 25;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start, stop;
  logic [31:0] window_ticks;
  logic        analyzer_enable, analyzer_clear, busy;
  logic [31:0] f0_value, f1_value, unknown;
  logic [15:0] overrun_count;
  state_t      state_dbg;

  fsk_measurement_controller_if rif ();

  fsk_measurement_controller #(
    .DEFAULT_WINDOW_TICKS  (DEF_WINDOW),
    .UNKNOWN_LIMIT_PERCENT (LIMIT_PCT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .window_ticks    (window_ticks),
    .analyzer_enable (analyzer_enable),
    .analyzer_clear  (analyzer_clear),
    .f0_value        (f0_value),
    .f1_value        (f1_value),
    .unknown         (unknown),
    .result_if       (rif),
    .busy            (busy),
    .overrun_count   (overrun_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- analyzer model ----------------
  int          tone_sel;   // 0: f0 tone, 1: f1 tone
  bit          noise_on;
  bit          direct_mode;
  logic [31:0] d_f0, d_f1, d_unk;
  logic [31:0] acc_f0, acc_f1, acc_unk;

  function automatic int pick_bin();
    int r;
    if (!noise_on) return tone_sel;
    r = $urandom_range(0, 9);
    if (r < 6) return tone_sel;
    return r % 3;
  endfunction

  always @(posedge clock) begin
    if (!analyzer_clear) begin
      acc_f0  <= '0;
      acc_f1  <= '0;
      acc_unk <= '0;
    end else if (analyzer_enable) begin
      case (pick_bin())
        0:       acc_f0  <= acc_f0 + 1;
        1:       acc_f1  <= acc_f1 + 1;
        default: acc_unk <= acc_unk + 1;
      endcase
    end
  end

  assign f0_value = direct_mode ? d_f0  : acc_f0;
  assign f1_value = direct_mode ? d_f1  : acc_f1;
  assign unknown  = direct_mode ? d_unk : acc_unk;

  // ---------------- reference symbol rule ----------------
  function automatic logic [1:0] ref_symbol(input longint unsigned a, input longint unsigned b,
                                            input longint unsigned c);
`ifdef FSK_CTRL_UNKNOWN_REJECT_EN
    if (c * 100 > (a + b + c) * LIMIT_PCT) return 2'd3;
`endif
    if (a > b && a > c) return 2'd1;
    if (b > a && b > c) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [95:0] exp_q[$];
  int en_cycles  = 0;
  int cap_count  = 0;
  int xfer_count = 0;
  int ovr_model  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor samples at the rising edge the values the DUT is about to act on.
  always @(posedge clock) begin
    if (!reset) begin
      if (analyzer_enable) en_cycles <= en_cycles + 1;
      if (rif.result_valid && rif.result_ready) begin
        xfer_count <= xfer_count + 1;
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          check("xfer_f0", rif.result_f0, e[95:64]);
          check("xfer_f1", rif.result_f1, e[63:32]);
          check("xfer_unk", rif.result_unknown, e[31:0]);
          check("xfer_sym", rif.result_symbol, ref_symbol(e[95:64], e[63:32], e[31:0]));
        end
      end
      if (state_dbg == CAPTURE) begin
        cap_count <= cap_count + 1;
        if (!rif.result_valid || rif.result_ready) exp_q.push_back({f0_value, f1_value, unknown});
        else if (ovr_model < 65535) ovr_model <= ovr_model + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (rif.result_valid !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  // Pulses start (optionally with stop) for one cycle; returns at the
  // falling edge where the first CLEAR cycle is visible.
  task automatic launch(input logic [31:0] win, input bit with_stop);
    @(negedge clock);
    window_ticks = win;
    start = 1'b1;
    stop  = with_stop;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic accept_one();
    rif.result_ready = 1'b1;
    @(negedge clock);
    rif.result_ready = 1'b0;
    check("valid_clears", rif.result_valid, 0);
  endtask

  // Single window with tone analyzer: checks CLEAR timing, enable length,
  // latency, symbol and the hold of the result until ready.
  task automatic tone_window(input string tag, input logic [31:0] win, input int tone,
                             input int exp_len);
    int n, base;
    logic [31:0] held;
    tone_sel = tone;
    noise_on = 1'b0;
    base = en_cycles;
    launch(win, 1'b1);
    check({tag, "_clear_state"}, state_dbg, CLEAR);
    check({tag, "_clear_low"}, analyzer_clear, 0);
    check({tag, "_busy"}, busy, 1);
    wait_valid(exp_len + 100, n);
    check({tag, "_latency"}, n, exp_len + 4);
    check({tag, "_en_cycles"}, en_cycles - base, exp_len);
    check({tag, "_symbol"}, rif.result_symbol, tone + 1);
    check({tag, "_count"}, tone == 0 ? rif.result_f0 : rif.result_f1, exp_len);
    check({tag, "_idle"}, busy, 0);
    held = rif.result_f0;
    repeat ($urandom_range(3, 10)) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, rif.result_valid, 1);
      check({tag, "_hold_f0"}, rif.result_f0, held);
    end
    accept_one();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, base;
    logic [31:0] first_f0, first_f1, first_unk;
    logic [31:0] va, vb, vc;

    reset = 1'b1; start = 0; stop = 0; window_ticks = 0;
    rif.result_ready = 0; tone_sel = 0; noise_on = 0; direct_mode = 0;
    d_f0 = 0; d_f1 = 0; d_unk = 0;
    repeat (3) @(negedge clock);
    check("rst_enable", analyzer_enable, 0);
    check("rst_clear", analyzer_clear, 1);
    check("rst_valid", rif.result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_count, 0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    @(negedge clock);

    // 9 kHz-like tone, 1000-cycle window, start+stop together -> one window
    tone_window("f0win", 32'd1000, 0, 1000);
    // 11 kHz-like tone, window_ticks=0 -> default window
    tone_window("f1def", 32'd0, 1, DEF_WINDOW);

    // Overrun: ready low across three windows of a continuous run
    noise_on = 1'b1;
    tone_sel = $urandom_range(0, 1);
    base = cap_count;
    launch($urandom_range(40, 80), 1'b0);
    wait_valid(400, n);
    first_f0 = exp_q[0][95:64]; first_f1 = exp_q[0][63:32]; first_unk = exp_q[0][31:0];
    check("ovr_first_f0", rif.result_f0, first_f0);
    n = 0;
    while (cap_count < base + 2 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) check("ovr_cap_timeout", 0, 1);
    tone_sel = 1 - tone_sel;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_idle(400);
    check("ovr_count", overrun_count, 2);
    check("ovr_held_f0", rif.result_f0, first_f0);
    check("ovr_held_f1", rif.result_f1, first_f1);
    check("ovr_held_unk", rif.result_unknown, first_unk);
    check("ovr_valid", rif.result_valid, 1);
    accept_one();
    launch($urandom_range(20, 40), 1'b1);
    wait_valid(400, n);
    check("ovr_next_valid", rif.result_valid, 1);
    accept_one();
    check("ovr_count_kept", overrun_count, 2);

    // Symbol rule with direct analyzer counts (ties, reject case, random)
    direct_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin va = 600; vb = 100; vc = 300; end
        1: begin va = 5;   vb = 5;   vc = 1;   end
        2: begin va = 1;   vb = 5;   vc = 5;   end
        3: begin va = 3;   vb = 3;   vc = 3;   end
        4: begin va = 32'hFFFF_FFFF; vb = 32'hFFFF_FFFF; vc = 32'hFFFF_FFFF; end
        default: begin
          if (i % 2 == 0) begin
            va = $urandom_range(0, 3); vb = $urandom_range(0, 3); vc = $urandom_range(0, 3);
          end else begin
            va = $urandom; vb = $urandom; vc = $urandom >> $urandom_range(0, 4);
          end
        end
      endcase
      d_f0 = va; d_f1 = vb; d_unk = vc;
      launch(32'd3, 1'b1);
      wait_valid(100, n);
      check("dir_symbol", rif.result_symbol, ref_symbol(va, vb, vc));
      if (i == 0) begin
`ifdef FSK_CTRL_UNKNOWN_REJECT_EN
        check("dir_reject_case", rif.result_symbol, 3);
`else
        check("dir_reject_case", rif.result_symbol, 1);
`endif
      end
      accept_one();
      wait_idle(50);
    end
    direct_mode = 1'b0;

    // Reset halfway through a 1000-cycle window
    noise_on = 1'b0;
    tone_sel = 0;
    base = en_cycles;
    launch(32'd1000, 1'b0);
    n = 0;
    while (en_cycles - base < 500 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    #1 reset = 1'b1;
    #1;
    check("mid_rst_enable", analyzer_enable, 0);
    check("mid_rst_clear", analyzer_clear, 1);
    check("mid_rst_valid", rif.result_valid, 0);
    check("mid_rst_symbol", rif.result_symbol, 0);
    check("mid_rst_f0", rif.result_f0, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun_count, 0);
    check("mid_rst_state", state_dbg, IDLE);
    exp_q.delete();
    ovr_model = 0;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (1200) begin
      @(negedge clock);
      if (rif.result_valid) n++;
    end
    check("mid_rst_no_result", n, 0);
    tone_window("restart", 32'd1000, 0, 1000);

    // Stop during the second window of a continuous run
    noise_on = 1'b1;
    tone_sel = 1;
    rif.result_ready = 1'b1;
    base = xfer_count;
    launch(32'd30, 1'b0);
    n = 0;
    while (xfer_count < base + 1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    while (state_dbg != MEASURE && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check("stop_timeout", 0, 1);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_idle(300);
    repeat (5) @(negedge clock);
    check("stop_xfers", xfer_count - base, 2);
    check("stop_busy", busy, 0);
    check("stop_clear", analyzer_clear, 1);
    check("stop_enable", analyzer_enable, 0);
    check("stop_state", state_dbg, IDLE);
    rif.result_ready = 1'b0;

    check("final_queue_empty", exp_q.size(), 0);
    check("final_overrun", overrun_count, ovr_model);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsk_measurement_controller.md
FSK_MEASUREMENT_CONTROLLER -- requirements
Module: fsk_measurement_controller

Interface
REQ-001 SHALL have parameter DEFAULT_WINDOW_TICKS, default 500000; window length used when window_ticks input is 0.
REQ-002 SHALL have parameter UNKNOWN_LIMIT_PERCENT, default 25; reject threshold (used only under REQ-024).
REQ-003 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start  in  1  (pulse, begin continuous measurement); stop  in  1  (pulse, end after current window).
REQ-006 SHALL have port window_ticks  in  32  measurement window length in clocks, sampled on accepted start.
REQ-007 SHALL have ports analyzer_enable  out  1; analyzer_clear  out  1  (active-low, analyzer convention).
REQ-008 SHALL have ports f0_value, f1_value, unknown  in  32 each  (analyzer accumulators).
REQ-009 SHALL have ports result_valid  out  1; result_ready  in  1; result_symbol  out  2.
REQ-010 SHALL have ports result_f0, result_f1, result_unknown  out  32 each; busy  out  1; overrun_count  out  16.

Function
REQ-011 SHALL implement states IDLE, CLEAR, MEASURE, SETTLE, CAPTURE.
REQ-012 IDLE: analyzer_enable=0, analyzer_clear=1, busy=0; start -> CLEAR; latch window length (window_ticks, or DEFAULT_WINDOW_TICKS if 0).
REQ-013 CLEAR: exactly 1 cycle, analyzer_clear=0, analyzer_enable=0 -> MEASURE.
REQ-014 MEASURE: analyzer_enable=1 for exactly the latched window length in cycles; 32-bit down-counter; -> SETTLE.
REQ-015 SETTLE: exactly 2 cycles, analyzer_enable=0, so analyzer flushes pending count into unknown -> CAPTURE.
REQ-016 CAPTURE: 1 cycle; register f0_value, f1_value, unknown, compute symbol; -> CLEAR if running, else IDLE.
REQ-017 symbol: 1 if f0>f1 and f0>unknown; 2 if f1>f0 and f1>unknown; else 0 (ties -> 0).
REQ-018 result handshake: result_valid rises cycle after CAPTURE; outputs stable while result_valid=1; transfer when result_valid & result_ready; result_valid clears next cycle.
REQ-019 overrun: CAPTURE while result_valid=1 and not accepted that cycle -> new result dropped, overrun_count increments, saturating at 65535.
REQ-020 CAPTURE coincident with acceptance -> new result loaded, result_valid stays 1, no overrun.
REQ-021 stop in any non-IDLE state sets stop-pending; window completes and is reported, then IDLE. Stop-pending cleared in IDLE.
REQ-022 start while busy ignored; start and stop same cycle in IDLE -> exactly one window then IDLE.
REQ-023 busy=1 in every state except IDLE.

Configuration
REQ-024 With FSK_CTRL_UNKNOWN_REJECT_EN defined: symbol=3 when unknown*100 > (f0+f1+unknown)*UNKNOWN_LIMIT_PERCENT. Sum SHALL be 34 bits, products 41 bits, no overflow. Rule overrides REQ-017.
REQ-025 Without it: symbol 3 never produced; no multiplier logic synthesized.

Reset
REQ-026 reset SHALL force IDLE asynchronously: analyzer_enable=0, analyzer_clear=1, result_valid=0, result_symbol=0, result_f0/f1/unknown=0, busy=0, overrun_count=0, stop-pending=0.
REQ-027 reset mid-MEASURE SHALL discard the window with no result; next start begins with CLEAR.

Structure
REQ-028 Shared package SHALL hold state enum, symbol codes (NONE=0, F0=1, F1=2, REJECT=3), SETTLE_CYCLES=2.
REQ-029 Symbol decision SHALL be sub-module fsk_symbol_decider: combinational, inputs three 32-bit counts, output 2-bit symbol; contains REQ-024 logic.

Verification
REQ-030 start, window_ticks=1000, 9 kHz tone at 50 MHz (2777-clock half period) -> CLEAR at cycle 1, 1000 enable cycles, result_symbol=1, result_valid held until ready.
REQ-031 11 kHz tone (2272-clock half period), window_ticks=0, DEFAULT_WINDOW_TICKS=20000 -> enable high 20000 cycles, symbol=2.
REQ-032 result_ready=0, three windows -> first result held unchanged, overrun_count=2; ready=1 -> transfer, next capture valid.
REQ-033 Macro defined, limit 25; analyzer counts f0=600, f1=100, unknown=300 -> symbol=3; macro undefined -> symbol=1.
REQ-034 reset at cycle 500 of a 1000-cycle window -> all outputs at reset values, no result_valid; restart -> full 1000-cycle window.
REQ-035 stop during 2nd window of continuous run -> 2nd result delivered, then IDLE, busy=0, analyzer_clear=1.
